cnn_dma_arbiter: RTL

CNN_DMA_ARBITER -- requirements
Module: cnn_dma_arbiter

---
 rtl/cnn_pkg.sv | 19 +
 rtl/cnn_rr_picker.sv | 26 ++
 rtl/cnn_dma_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared CNN accelerator constants and the DMA arbiter state encoding.
package cnn_pkg;

  localparam int unsigned MEM_ADDR_SIZE = 20;
  localparam int unsigned DATA_SIZE     = 16;
  localparam int unsigned BLOCK_SIZE    = 150;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StXfer = 2'd1,
    StDone = 2'd2
  } arb_state_e;

  // Index width that stays at least one bit wide for degenerate sizes.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_rr_picker.sv
// Rotating-priority picker: first set request at or after rr_ptr_i, wrapping to 0.
module cnn_rr_picker #(
  parameter int unsigned NReq = 4,
  localparam int unsigned IdxW = cnn_pkg::idx_width(NReq)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] rr_ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  always_comb begin
    int unsigned j;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int unsigned i = 0; i < NReq; i++) begin
      j = (32'(rr_ptr_i) + i) % NReq;
      if (!valid_o && req_i[IdxW'(j)]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/cnn_dma_arbiter.sv
// Round-robin arbiter granting one DMA transfer at a time to the CNN requesters,
// with a per-transfer completion timeout.
module cnn_dma_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned MEM_ADDR_SIZE = cnn_pkg::MEM_ADDR_SIZE,
  parameter int unsigned LEN_W         = 8,
  parameter int unsigned TIMEOUT       = 1023,
  localparam int unsigned IdxW         = cnn_pkg::idx_width(N_REQ)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0]                 req_write,
  input  logic [N_REQ*MEM_ADDR_SIZE-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]           req_len,
  output logic [N_REQ-1:0]                 req_ready,
  output logic [N_REQ-1:0]                 req_done,
  output logic [N_REQ-1:0]                 req_err,
  output logic                             dma_enable,
  output logic                             dma_write,
  output logic [MEM_ADDR_SIZE-1:0]         dma_addr,
  output logic [LEN_W-1:0]                 dma_len,
  input  logic                             dma_done,
  output logic [IdxW-1:0]                  grant_id,
  output logic                             busy
);

  import cnn_pkg::*;

  localparam int unsigned CntW = idx_width(TIMEOUT + 1);

  arb_state_e       state_q;
  logic [IdxW-1:0]  rr_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             pick_valid;
  logic [IdxW-1:0]  pick_idx;

  logic [MEM_ADDR_SIZE-1:0] addr_arr [N_REQ];
  logic [LEN_W-1:0]         len_arr  [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign addr_arr[i] = req_addr[i*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
    assign len_arr[i]  = req_len[i*LEN_W +: LEN_W];
  end

  cnn_rr_picker #(
    .NReq(N_REQ)
  ) u_picker (
    .req_i   (req_valid),
    .rr_ptr_i(rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      grant_id   <= '0;
      req_ready  <= '0;
      req_done   <= '0;
      req_err    <= '0;
      dma_enable <= 1'b0;
      dma_write  <= 1'b0;
      dma_addr   <= '0;
      dma_len    <= '0;
    end else begin
      req_ready <= '0;
      req_done  <= '0;
      req_err   <= '0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant_id   <= pick_idx;
            dma_write  <= req_write[pick_idx];
            dma_addr   <= addr_arr[pick_idx];
            dma_len    <= len_arr[pick_idx];
            // Zero-length requests are acknowledged without touching the DMA.
            dma_enable <= (len_arr[pick_idx] != '0);
            cnt_q      <= '0;
            req_ready  <= N_REQ'(1) << pick_idx;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          // A done arriving on the timeout edge still counts as success.
          if (dma_done || (dma_len == '0)) begin
            dma_enable <= 1'b0;
            req_done   <= N_REQ'(1) << grant_id;
            state_q    <= StDone;
          end else if (cnt_q == CntW'(TIMEOUT)) begin
            dma_enable <= 1'b0;
            req_done   <= N_REQ'(1) << grant_id;
            req_err    <= N_REQ'(1) << grant_id;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          rr_ptr_q <= (grant_id == IdxW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
